// File: rtl/atm_keypad_pkg.sv
// Shared constants, state encoding and range limits for the ATM keypad entry block.
package atm_keypad_pkg;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam int ACC_W    = 14;
  localparam int CNT_W    = 3;
  localparam int CARD_MAX = 4095;
  localparam int PIN_MAX  = 255;

  typedef enum logic [1:0] {
    CARD_ENTRY,
    CARD_SEND,
    PIN_ENTRY,
    PIN_SEND
  } keypadState_t;

  function automatic logic isDigit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_keypad_entry_decimal_accumulator.sv
// Decimal accumulator: acc = acc*10 + digit with a digit counter capped at a
// per-field limit; clear has priority over a digit in the same cycle.
module decimal_accumulator
  import atm_keypad_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             digitValid,
  input  logic [3:0]       digit,
  input  logic [CNT_W-1:0] limit,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count
);

  logic [ACC_W-1:0] accTimesTen;

  // The digit limit bounds the value, so the 14-bit product never wraps.
  assign accTimesTen = (acc << 3) + (acc << 1);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc   <= '0;
      count <= '0;
    end else if (digitValid && (count < limit)) begin
      acc   <= accTimesTen + ACC_W'(digit);
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad front-end: card number then PIN, range-checked and handed off over valid/ready.
// Optional inactivity abort is built when KEYPAD_TIMEOUT_EN is defined.
module atm_keypad_entry
  import atm_keypad_pkg::*;
#(
  parameter int CARD_DIGITS    = 4,
  parameter int PIN_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_is_pin,
  output logic [11:0]      card_number,
  output logic [7:0]       pin_number,
  output logic [CNT_W-1:0] digit_count,
  output logic             entry_error,
  output logic             timeout,
  output logic             cancel
);

  localparam logic [CNT_W-1:0] CARD_CNT = CNT_W'(CARD_DIGITS);
  localparam logic [CNT_W-1:0] PIN_CNT  = CNT_W'(PIN_DIGITS);

  keypadState_t     state;
  logic             inEntry;
  logic             keyDigit;
  logic             keyClear;
  logic             keyEnter;
  logic             keyCancel;
  logic             enterOk;
  logic             handshake;
  logic             accClear;
  logic             timeoutFire;
  logic [CNT_W-1:0] limit;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] rangeMax;

  assign inEntry   = (state == CARD_ENTRY) || (state == PIN_ENTRY);
  assign keyDigit  = inEntry && key_valid && isDigit(key_code);
  assign keyClear  = inEntry && key_valid && (key_code == KEY_CLEAR);
  assign keyEnter  = inEntry && key_valid && (key_code == KEY_ENTER);
  assign keyCancel = inEntry && key_valid && (key_code == KEY_CANCEL);
  assign handshake = out_valid && out_ready;

  assign limit    = (state == PIN_ENTRY) ? PIN_CNT : CARD_CNT;
  assign rangeMax = (state == PIN_ENTRY) ? ACC_W'(PIN_MAX) : ACC_W'(CARD_MAX);
  assign enterOk  = (digit_count != '0) && (digit_count == limit) && (acc <= rangeMax);

  // A successful ENTER keeps acc until the handshake, where it clears.
  assign accClear = keyClear || keyCancel || (keyEnter && !enterOk) || handshake || timeoutFire;

  decimal_accumulator u_acc (
    .clk        (clk),
    .reset      (reset),
    .clear      (accClear),
    .digitValid (keyDigit),
    .digit      (key_code),
    .limit      (limit),
    .acc        (acc),
    .count      (digit_count)
  );

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMER_W-1:0] idleTimer;
  logic               timerRun;
  logic               keyAccepted;

  assign keyAccepted = inEntry && key_valid && (key_code <= KEY_CANCEL);
  assign timerRun    = (state == PIN_ENTRY) || ((state == CARD_ENTRY) && (digit_count != '0));
  assign timeoutFire = timerRun && !keyAccepted && (idleTimer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idleTimer <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= timeoutFire;
      if (!timerRun || keyAccepted || timeoutFire) idleTimer <= '0;
      else                                          idleTimer <= idleTimer + 1'b1;
    end
  end
`else
  assign timeoutFire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CARD_ENTRY;
      out_valid   <= 1'b0;
      out_is_pin  <= 1'b0;
      card_number <= '0;
      pin_number  <= '0;
      entry_error <= 1'b0;
      cancel      <= 1'b0;
    end else begin
      entry_error <= 1'b0;
      cancel      <= 1'b0;
      case (state)
        CARD_ENTRY, PIN_ENTRY: begin
          if (timeoutFire || keyCancel) begin
            cancel      <= keyCancel;
            card_number <= '0;
            pin_number  <= '0;
            state       <= CARD_ENTRY;
          end else if (keyEnter) begin
            if (!enterOk) begin
              entry_error <= 1'b1;
            end else if (state == CARD_ENTRY) begin
              card_number <= acc[11:0];
              out_valid   <= 1'b1;
              out_is_pin  <= 1'b0;
              state       <= CARD_SEND;
            end else begin
              pin_number <= acc[7:0];
              out_valid  <= 1'b1;
              out_is_pin <= 1'b1;
              state      <= PIN_SEND;
            end
          end
        end
        CARD_SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            state     <= PIN_ENTRY;
          end
        end
        PIN_SEND: begin
          if (handshake) begin
            out_valid  <= 1'b0;
            out_is_pin <= 1'b0;
            state      <= CARD_ENTRY;
          end
        end
        default: state <= CARD_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Scoreboard bench for atm_keypad_entry: directed key strings push expected events,
// a negedge monitor pops and compares whenever the DUT presents a value or a pulse.
module tb_atm_keypad_entry;
  import atm_keypad_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic        out_is_pin;
  logic [11:0] card_number;
  logic [7:0]  pin_number;
  logic [2:0]  digit_count;
  logic        entry_error;
  logic        timeout;
  logic        cancel;

  atm_keypad_entry #(
    .CARD_DIGITS    (4),
    .PIN_DIGITS     (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_is_pin  (out_is_pin),
    .card_number (card_number),
    .pin_number  (pin_number),
    .digit_count (digit_count),
    .entry_error (entry_error),
    .timeout     (timeout),
    .cancel      (cancel)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_CARD, EV_PIN, EV_ERR, EV_CANCEL, EV_TIMEOUT} ev_t;
  typedef struct {
    ev_t kind;
    int  value;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   timeoutsSeen = 0;

  task automatic check(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expectEv(input ev_t kind, input int value);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    expQ.push_back(e);
  endtask

  // Digits '0'-'9', C = CLEAR, E = ENTER, X = CANCEL; one key per cycle.
  task automatic keyString(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte        c;
      logic [3:0] code;
      c = s[i];
      case (c)
        "C":     code = KEY_CLEAR;
        "E":     code = KEY_ENTER;
        "X":     code = KEY_CANCEL;
        default: code = 4'(c - "0");
      endcase
      key_valid = 1'b1;
      key_code  = code;
      @(posedge clk);
      #1;
    end
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    if (expQ.size() != 0) begin
      check({name, "_pending_events"}, expQ.size(), 0);
      expQ.delete();
    end
  endtask

  ev_t gotKind;
  int  gotVal;
  bit  gotAny;
  exp_t popped;

  always @(negedge clk) begin
    if (!reset) begin
      gotAny = 1'b1;
      gotVal = 0;
      if (out_valid && out_ready) begin
        gotKind = out_is_pin ? EV_PIN : EV_CARD;
        gotVal  = out_is_pin ? int'(pin_number) : int'(card_number);
      end else if (entry_error) gotKind = EV_ERR;
      else if (cancel)          gotKind = EV_CANCEL;
      else if (timeout)         gotKind = EV_TIMEOUT;
      else                      gotAny  = 1'b0;
      if (gotAny) begin
        if (gotKind == EV_TIMEOUT) timeoutsSeen++;
        if (expQ.size() == 0) begin
          check("unexpected_event_kind", int'(gotKind), -1);
        end else begin
          popped = expQ.pop_front();
          check("event_kind", int'(gotKind), int'(popped.kind));
          check("event_value", gotVal, popped.value);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_is_pin", out_is_pin, 0);
    check("reset_card", card_number, 0);
    check("reset_pin", pin_number, 0);
    check("reset_count", digit_count, 0);
    check("reset_error", entry_error, 0);
    check("reset_cancel", cancel, 0);
    check("reset_timeout", timeout, 0);
    reset = 1'b0;
    idle(1);

    expectEv(EV_CARD, 1281);
    keyString("1281E");
    drain("card_1281");
    check("count_after_card_hs", digit_count, 0);

    out_ready = 1'b0;
    expectEv(EV_PIN, 205);
    keyString("205E");
    keyString("7XC3E");
    check("bp_out_valid", out_valid, 1);
    check("bp_out_is_pin", out_is_pin, 1);
    check("bp_pin", pin_number, 205);
    check("bp_card", card_number, 1281);
    check("bp_count", digit_count, 3);
    out_ready = 1'b1;
    drain("pin_205");
    idle(1);
    check("out_valid_after_hs", out_valid, 0);

    expectEv(EV_ERR, 0);
    keyString("9602E");
    drain("card_range");
    check("count_after_range_err", digit_count, 0);

    expectEv(EV_ERR, 0);
    keyString("12E");
    drain("card_short");

    expectEv(EV_ERR, 0);
    keyString("E");
    drain("card_empty");

    expectEv(EV_CARD, 1281);
    keyString("12817E");
    drain("card_extra_digit");

    expectEv(EV_ERR, 0);
    keyString("300E");
    drain("pin_range");

    expectEv(EV_PIN, 42);
    keyString("042E");
    drain("pin_42");

    expectEv(EV_CARD, 1281);
    keyString("5C1281E");
    drain("card_clear");

    expectEv(EV_CANCEL, 0);
    keyString("20X");
    drain("pin_cancel");
    check("cancel_card_zero", card_number, 0);
    check("cancel_count", digit_count, 0);

    expectEv(EV_ERR, 0);
    keyString("4096E");
    drain("card_4096");
    expectEv(EV_CARD, 4095);
    keyString("4095E");
    drain("card_4095");
    expectEv(EV_PIN, 255);
    keyString("255E");
    drain("pin_255");

    expectEv(EV_CARD, 1281);
    keyString("1281E");
    drain("card_before_reset");
    keyString("20");
    reset = 1'b1;
    idle(2);
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_card", card_number, 0);
    check("mid_reset_pin", pin_number, 0);
    check("mid_reset_count", digit_count, 0);
    check("mid_reset_is_pin", out_is_pin, 0);
    reset = 1'b0;
    idle(1);

    expectEv(EV_CARD, 7);
    keyString("0007E");
    drain("card_after_reset");
    expectEv(EV_PIN, 1);
    keyString("001E");
    drain("pin_after_reset");

    keyString("12");
`ifdef KEYPAD_TIMEOUT_EN
    expectEv(EV_TIMEOUT, 0);
    idle(20);
    drain("timeout");
    check("timeout_count", digit_count, 0);
    check("timeout_pulses", timeoutsSeen, 1);
`else
    idle(100);
    check("no_timeout_count", digit_count, 2);
    check("no_timeout_pulses", timeoutsSeen, 0);
    keyString("C");
`endif

    idle(2);
    check("queue_empty_at_end", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
